// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and control-bus constants for the pipeline stall/flush scheduler.
// Bit order: stall [0]PC..[3]EX_MEM, flush [0]IF_ID..[3]MEM_WB.
package pipeline_ctrl_pkg;

  localparam int STALL_W      = 4;
  localparam int FLUSH_W      = 4;
  localparam int MC_LEN_W_DEF = 6;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_MULTI = 2'd1,
    CTRL_FLUSH = 2'd2
  } ctrl_state_e;

  localparam logic [STALL_W-1:0] STALL_NONE = 4'b0000;
  localparam logic [STALL_W-1:0] STALL_MEM  = 4'b1111;
  localparam logic [STALL_W-1:0] STALL_MC   = 4'b0111;
  localparam logic [STALL_W-1:0] STALL_LU   = 4'b0011;

  localparam logic [FLUSH_W-1:0] FLUSH_NONE = 4'b0000;
  localparam logic [FLUSH_W-1:0] FLUSH_ALL  = 4'b1111;
  localparam logic [FLUSH_W-1:0] FLUSH_WB   = 4'b1000;
  localparam logic [FLUSH_W-1:0] FLUSH_MEM  = 4'b0100;
  localparam logic [FLUSH_W-1:0] FLUSH_EX   = 4'b0010;
  localparam logic [FLUSH_W-1:0] FLUSH_ID   = 4'b0001;

endpackage

// File: rtl/pipeline_ctrl.sv
// Central stall/flush scheduler: merges hazard, multi-cycle EX,
// memory stall and exception requests into per-register hold/bubble controls.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MC_LEN_W = MC_LEN_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_stallReq,
  input  logic                id_branchTaken,
  input  logic                ex_mcStart,
  input  logic [MC_LEN_W-1:0] ex_mcLen,
  input  logic                mem_stallReq,
  input  logic                mem_excReq,
  output logic [STALL_W-1:0]  stall,
  output logic [FLUSH_W-1:0]  flush,
  output logic                pc_redirect,
  output logic                ex_mcDone,
  output logic                ex_mcAbort
);

  ctrl_state_e         state_q, state_d;
  logic [MC_LEN_W-1:0] cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                abort_q, abort_d;

  logic mc_go;
  logic mc_busy;

  assign mc_go   = ex_mcStart && (ex_mcLen != '0);
  assign mc_busy = (state_q == CTRL_MULTI) ||
                   ((state_q == CTRL_RUN) && mc_go);

  // Same-cycle response; the priority chain keeps flush and stall disjoint.
  always_comb begin
    stall       = STALL_NONE;
    flush       = FLUSH_NONE;
    pc_redirect = 1'b0;
    if (!rst) begin
      stall       = STALL_NONE;
    end else if (mem_excReq) begin
      flush       = FLUSH_ALL;
      pc_redirect = 1'b1;
    end else if (mem_stallReq) begin
      stall = STALL_MEM;
      flush = FLUSH_WB;
    end else if (state_q == CTRL_FLUSH) begin
      flush = FLUSH_ID;
    end else if (mc_busy) begin
      stall = STALL_MC;
      flush = FLUSH_MEM;
    end else if (id_stallReq) begin
      stall = STALL_LU;
      flush = FLUSH_EX;
    end else if (id_branchTaken) begin
      flush = FLUSH_ID;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    if (mem_excReq) begin
      state_d = CTRL_FLUSH;
      cnt_d   = '0;
      abort_d = (state_q == CTRL_MULTI);
    end else if (!mem_stallReq) begin
      unique case (state_q)
        CTRL_FLUSH: state_d = CTRL_RUN;
        CTRL_MULTI: begin
          if (cnt_q <= MC_LEN_W'(1)) begin
            cnt_d   = '0;
            state_d = CTRL_RUN;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - MC_LEN_W'(1);
          end
        end
        CTRL_RUN: begin
          if (mc_go) begin
            if (ex_mcLen == MC_LEN_W'(1)) begin
              done_d = 1'b1;
            end else begin
              cnt_d   = ex_mcLen - MC_LEN_W'(1);
              state_d = CTRL_MULTI;
            end
          end
        end
        default: state_d = CTRL_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CTRL_RUN;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign ex_mcDone  = done_q;
  assign ex_mcAbort = abort_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios then random traffic,
// all compared against a cycle-count reference model.
module tb_pipeline_ctrl;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         id_stallReq;
  logic         id_branchTaken;
  logic         ex_mcStart;
  logic [W-1:0] ex_mcLen;
  logic         mem_stallReq;
  logic         mem_excReq;
  logic [3:0]   stall;
  logic [3:0]   flush;
  logic         pc_redirect;
  logic         ex_mcDone;
  logic         ex_mcAbort;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  // Reference: stall cycles still owed by the op, pending FLUSH cycle, pulses.
  int mc_left   = 0;
  bit flush_pnd = 0;
  bit done_exp  = 0;
  bit abort_exp = 0;

  pipeline_ctrl #(.MC_LEN_W(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_stallReq    (id_stallReq),
    .id_branchTaken (id_branchTaken),
    .ex_mcStart     (ex_mcStart),
    .ex_mcLen       (ex_mcLen),
    .mem_stallReq   (mem_stallReq),
    .mem_excReq     (mem_excReq),
    .stall          (stall),
    .flush          (flush),
    .pc_redirect    (pc_redirect),
    .ex_mcDone      (ex_mcDone),
    .ex_mcAbort     (ex_mcAbort)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h",
               tag, cyc_n, got, exp);
    end
  endtask

  task automatic drive(input bit exc, input bit ms, input bit st,
                       input logic [W-1:0] len, input bit ld,
                       input bit br);
    mem_excReq     = exc;
    mem_stallReq   = ms;
    ex_mcStart     = st;
    ex_mcLen       = len;
    id_stallReq    = ld;
    id_branchTaken = br;
  endtask

  // One clock: drive, check outputs at negedge, advance model at posedge.
  task automatic cyc(input bit exc, input bit ms, input bit st,
                     input logic [W-1:0] len, input bit ld,
                     input bit br);
    logic [3:0] es;
    logic [3:0] ef;
    bit         er;
    drive(exc, ms, st, len, ld, br);
    es = 4'h0;
    ef = 4'h0;
    er = 1'b0;
    if (exc) begin
      ef = 4'hf;
      er = 1'b1;
    end else if (ms) begin
      es = 4'hf;
      ef = 4'h8;
    end else if (flush_pnd) begin
      ef = 4'h1;
    end else if (mc_left > 0 || (st && len != 0)) begin
      es = 4'h7;
      ef = 4'h4;
    end else if (ld) begin
      es = 4'h3;
      ef = 4'h2;
    end else if (br) begin
      ef = 4'h1;
    end
    @(negedge clk);
    check("stall", 32'(stall), 32'(es));
    check("flush", 32'(flush), 32'(ef));
    check("redirect", 32'(pc_redirect), 32'(er));
    check("mc_done", 32'(ex_mcDone), 32'(done_exp));
    check("mc_abort", 32'(ex_mcAbort), 32'(abort_exp));
    @(posedge clk);
    done_exp  = 0;
    abort_exp = 0;
    if (exc) begin
      abort_exp = (mc_left > 0);
      mc_left   = 0;
      flush_pnd = 1;
    end else if (ms) begin
      mc_left = mc_left;
    end else if (flush_pnd) begin
      flush_pnd = 0;
    end else if (mc_left > 0) begin
      mc_left--;
      done_exp = (mc_left == 0);
    end else if (st && len != 0) begin
      mc_left  = int'(len) - 1;
      done_exp = (len == 1);
    end
    cyc_n++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    drive(1, 1, 1, 6'd3, 1, 1);
    #1;
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_redirect", 32'(pc_redirect), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 0, 0, '0, 0, 0);
    idle(2);

    // Reset asserted mid-op with cnt at 5.
    cyc(0, 0, 1, 6'd8, 0, 0);
    idle(2);
    rst = 1'b0;
    drive(1, 0, 1, 6'd4, 1, 1);
    #1;
    check("rstmid_stall", 32'(stall), 32'h0);
    check("rstmid_flush", 32'(flush), 32'h0);
    check("rstmid_redirect", 32'(pc_redirect), 32'h0);
    @(posedge clk);
    #1;
    check("rstmid_done", 32'(ex_mcDone), 32'h0);
    check("rstmid_abort", 32'(ex_mcAbort), 32'h0);
    rst = 1'b1;
    mc_left   = 0;
    flush_pnd = 0;
    done_exp  = 0;
    abort_exp = 0;
    idle(3);

    // Load-use, then divides of length 4 and 1.
    cyc(0, 0, 0, '0, 1, 0);
    idle(1);
    cyc(0, 0, 1, 6'd4, 0, 0);
    idle(5);
    cyc(0, 0, 1, 6'd1, 0, 0);
    idle(2);
    cyc(0, 0, 1, 6'd0, 0, 0);
    idle(1);

    // Memory stall inside an op of length 4.
    cyc(0, 0, 1, 6'd4, 0, 0);
    cyc(0, 0, 0, '0, 0, 0);
    cyc(0, 1, 1, 6'd2, 0, 0);
    cyc(0, 1, 0, '0, 0, 0);
    idle(4);

    // Exception during an op.
    cyc(0, 0, 1, 6'd6, 0, 0);
    idle(1);
    cyc(1, 0, 0, '0, 0, 0);
    idle(3);

    // Exception while already flushing restarts the flush.
    cyc(1, 0, 0, '0, 0, 0);
    cyc(1, 0, 1, 6'd3, 1, 1);
    cyc(0, 0, 1, 6'd3, 1, 1);
    idle(5);

    // Simultaneous requests.
    cyc(0, 0, 0, '0, 1, 1);
    cyc(0, 1, 0, '0, 0, 0);
    cyc(1, 1, 0, '0, 0, 0);
    idle(2);
    cyc(0, 1, 0, '0, 0, 1);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      bit           exc, ms, st, ld, br;
      logic [W-1:0] len;
      exc = ($urandom_range(0, 99) < 4);
      ms  = ($urandom_range(0, 99) < 15);
      st  = ($urandom_range(0, 99) < 25);
      ld  = ($urandom_range(0, 99) < 20);
      br  = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 19) == 0)
        len = W'($urandom_range(0, 63));
      else
        len = W'($urandom_range(0, 6));
      cyc(exc, ms, st, len, ld, br);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
